// File: rtl/tag_scroll_display.sv
// Latches a 128-bit word and scrolls it, 4 hex digits at a time, across a
// 4-digit multiplexed active-low 7-segment display.
module tag_scroll_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SCROLL_DIV  = 200000000
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic [0:127] i_data,
  input  logic         i_load,
  input  logic         i_hold,
  output logic [3:0]   o_an,
  output logic [6:0]   o_seg,
  output logic         o_dp,
  output logic [2:0]   o_window,
  output logic         o_valid
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned SW = $clog2(SCROLL_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);

  logic [0:127]  r_data;
  logic [RW-1:0] r_ref;
  logic [SW-1:0] r_scroll;
  logic [1:0]    r_digit;
  logic [2:0]    r_win;
  logic          r_valid;

  logic [6:0]    w_base;
  logic [3:0]    w_nib;
  logic [6:0]    w_seg;

  // Bit 0 of the word is its MSB, so the lowest index of each slice is the nibble MSB.
  assign w_base  = {r_win, 4'b0000} + {3'b000, 2'd3 - r_digit, 2'b00};
  assign w_nib   = r_data[w_base +: 4];
  assign o_valid = r_valid;

  always_comb begin
    w_seg = '1;
    case (w_nib)
      4'h0: w_seg = 7'b0000001;
      4'h1: w_seg = 7'b1001111;
      4'h2: w_seg = 7'b0010010;
      4'h3: w_seg = 7'b0000110;
      4'h4: w_seg = 7'b1001100;
      4'h5: w_seg = 7'b0100100;
      4'h6: w_seg = 7'b0100000;
      4'h7: w_seg = 7'b0001111;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0000100;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b1100000;
      4'hC: w_seg = 7'b0110001;
      4'hD: w_seg = 7'b1000010;
      4'hE: w_seg = 7'b0110000;
      4'hF: w_seg = 7'b0111000;
      default: w_seg = '1;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_ref   <= '0;
      r_digit <= '0;
    end else if (r_ref == REF_LAST) begin
      r_ref   <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_ref   <= r_ref + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_win    <= '0;
      r_scroll <= '0;
    end else if (i_load) begin
      r_data   <= i_data;
      r_valid  <= 1'b1;
      r_win    <= '0;
      r_scroll <= '0;
    end else if (r_valid && !i_hold) begin
      if (r_scroll == SCR_LAST) begin
        r_scroll <= '0;
        r_win    <= r_win + 3'd1;
      end else begin
        r_scroll <= r_scroll + 1'b1;
      end
    end
  end

  // Anode and segment registers share one edge so a digit never shows its neighbour's pattern.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_an     <= '1;
      o_seg    <= '1;
      o_dp     <= 1'b1;
      o_window <= '0;
    end else begin
      o_an     <= r_valid ? ~(4'b0001 << r_digit) : 4'b1111;
      o_seg    <= r_valid ? w_seg : 7'b1111111;
      o_dp     <= ~(r_valid && (r_digit == 2'd0) && (r_win == 3'd0));
      o_window <= r_win;
    end
  end

endmodule

// File: tb/tb_tag_scroll_display.sv
// Randomised scoreboard bench for tag_scroll_display with a cycle-count
// reference model (REFRESH_DIV=4, SCROLL_DIV=64).
module tb_tag_scroll_display;

  localparam int unsigned RDIV = 4;
  localparam int unsigned SDIV = 64;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] win;
    logic       valid;
  } exp_t;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic [127:0] i_data = '0;
  logic         i_load = 1'b0;
  logic         i_hold = 1'b0;
  logic [3:0]   o_an;
  logic [6:0]   o_seg;
  logic         o_dp;
  logic [2:0]   o_window;
  logic         o_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        q[$];

  int unsigned  m_t = 0;
  int unsigned  m_n = 0;
  logic         m_valid = 1'b0;
  logic [127:0] m_word = '0;

  logic [6:0] seg_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  tag_scroll_display #(.REFRESH_DIV(RDIV), .SCROLL_DIV(SDIV)) dut (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_load(i_load), .i_hold(i_hold),
    .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp), .o_window(o_window), .o_valid(o_valid));

  always #5 clk = ~clk;

  // Monitor: reset values while reset is high, otherwise the queued expectation.
  always @(posedge clk or posedge i_reset) begin
    exp_t e;
    exp_t act;
    #1;
    act = {o_an, o_seg, o_dp, o_window, o_valid};
    if (i_reset) begin
      e = {4'b1111, 7'b1111111, 1'b1, 3'd0, 1'b0};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL reset_state t=%0t got an=%b seg=%b dp=%b win=%0d valid=%b want an=%b seg=%b dp=%b win=%0d valid=%b",
                 $time, act.an, act.seg, act.dp, act.win, act.valid, e.an, e.seg, e.dp, e.win, e.valid);
      end
    end else if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL display t=%0t got an=%b seg=%b dp=%b win=%0d valid=%b want an=%b seg=%b dp=%b win=%0d valid=%b",
                 $time, act.an, act.seg, act.dp, act.win, act.valid, e.an, e.seg, e.dp, e.win, e.valid);
      end
    end
  end

  // One clock of stimulus: expectation from the model's pre-edge state, then model advance.
  task automatic drive(input logic ld, input logic hd, input logic [127:0] dat);
    exp_t e;
    int unsigned d, w, k;
    i_load = ld;
    i_hold = hd;
    i_data = dat;
    d = (m_t / RDIV) % 4;
    w = (m_n / SDIV) % 8;
    k = 4 * w + (3 - d);
    e.an  = m_valid ? ~(4'b0001 << d) : 4'b1111;
    e.seg = m_valid ? seg_tbl[m_word[127 - 4 * k -: 4]] : 7'b1111111;
    e.dp  = !(m_valid && d == 0 && w == 0);
    e.win = 3'(w);
    m_t++;
    if (ld) begin
      m_word  = dat;
      m_valid = 1'b1;
      m_n     = 0;
    end else if (m_valid && !hd) begin
      m_n++;
    end
    e.valid = m_valid;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_t = 0;
    m_n = 0;
    m_valid = 1'b0;
    m_word = '0;
  endtask

  // Asserted between edges so the asynchronous path is observed before the next clock.
  task automatic pulse_reset();
    #1;
    i_reset = 1'b1;
    i_load  = 1'b0;
    q.delete();
    @(posedge clk);
    #2;
    i_reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] w1;
    w1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    repeat (3) @(posedge clk);
    #2;
    i_reset = 1'b0;
    model_reset();

    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, rnd128());

    drive(1'b1, 1'b1, w1);
    for (int i = 0; i < 24; i++) drive(1'b0, 1'b1, '0);

    for (int i = 0; i < 8 * SDIV + 40; i++) drive(1'b0, 1'b0, '0);

    for (int i = 0; i < 600 && (m_n % 512) != 255; i++) drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, rnd128());
    for (int i = 0; i < 150; i++) drive(1'b0, 1'b0, '0);

    for (int i = 0; i < 600 && (m_n % 512) != 5 * SDIV + 20; i++) drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 500; i++) drive(1'b0, 1'b1, '0);
    for (int i = 0; i < 120; i++) drive(1'b0, 1'b0, '0);

    for (int i = 0; i < 600 && (m_n % 512) != 6 * SDIV + 10; i++) drive(1'b0, 1'b0, '0);
    pulse_reset();
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b0, rnd128());

    drive(1'b1, 1'b0, rnd128());
    for (int i = 0; i < 2000; i++) begin
      logic ld, hd;
      ld = ($urandom_range(0, 99) == 0);
      hd = (i % 300) > 240 ? 1'b1 : ($urandom_range(0, 19) == 0);
      drive(ld, hd, rnd128());
    end

    i_load = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
